// File: rtl/dmem_bridge.sv
`default_nettype none
// ============================================================================
// Module      : dmem_bridge
// Description : Bridges single-cycle datapath load/store requests to a
//               handshaked external memory bus, stalling the core meanwhile.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_bridge #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemWrite,
    input  logic        MemRead,
    input  logic [31:0] ALUResult,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        Stall,
    output logic        Err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [7:0]  C_TIMEOUT  = 8'(TIMEOUT);
    localparam logic [31:0] C_BAD_DATA = 32'hDEADBEEF;

    state_t     r_state;
    logic [7:0] r_cnt;

    logic w_acc;
    logic w_aligned;
    logic w_start;
    logic w_timeout;

    assign w_acc     = MemRead | MemWrite;
    assign w_aligned = (ALUResult[1:0] == 2'b00);
    assign w_start   = (r_state == ST_IDLE) & w_acc & w_aligned;
    // Count after this REQ cycle equals the limit: this is the last cycle allowed.
    assign w_timeout = ((r_cnt + 8'd1) == C_TIMEOUT);

    // Stall must drop the instant reset asserts, even with a request pending.
    always_comb begin
        Stall = 1'b0;
        if (!rst) begin
            Stall = w_start | (r_state == ST_REQ);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= 8'd0;
            ReadData  <= 32'd0;
            Err       <= 1'b0;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= 32'd0;
            bus_wdata <= 32'd0;
        end else begin
            Err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_acc) begin
                        if (w_aligned) begin
                            r_state   <= ST_REQ;
                            r_cnt     <= 8'd0;
                            bus_req   <= 1'b1;
                            bus_we    <= MemWrite;
                            bus_addr  <= ALUResult;
                            bus_wdata <= WriteData;
                        end else begin
                            Err <= 1'b1;
                        end
                    end
                end
                ST_REQ: begin
                    // Ack takes priority over an expiring timeout.
                    if (bus_ack) begin
                        bus_req <= 1'b0;
                        r_state <= ST_DONE;
                        if (!bus_we) begin
                            ReadData <= bus_rdata;
                        end
                    end else if (w_timeout) begin
                        bus_req <= 1'b0;
                        Err     <= 1'b1;
                        r_cnt   <= r_cnt + 8'd1;
                        r_state <= ST_DONE;
                        if (!bus_we) begin
                            ReadData <= C_BAD_DATA;
                        end
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/dmem_bridge.md
DMEM_BRIDGE -- requirements
Module: dmem_bridge

Interface
REQ-001 Parameter TIMEOUT, default 16, SHALL set the maximum number of REQ-state cycles waiting for bus_ack; legal range 1..255.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 MemWrite  input  1  store request from the control unit for the current instruction.
REQ-005 MemRead  input  1  load request from the control unit for the current instruction.
REQ-006 ALUResult  input  32  byte address from the datapath ALU.
REQ-007 WriteData  input  32  store data from the datapath register file.
REQ-008 ReadData  output  32  registered load data returned to the datapath MemtoReg mux.
REQ-009 Stall  output  1  high means the processor SHALL hold PC and suppress regWrite this cycle.
REQ-010 Err  output  1  one-cycle error pulse for a misaligned access or a timeout.
REQ-011 bus_req  output  1  registered request to the external memory.
REQ-012 bus_we  output  1  registered write strobe; 1 means store.
REQ-013 bus_addr  output  32  registered, latched address.
REQ-014 bus_wdata  output  32  registered, latched store data.
REQ-015 bus_ack  input  1  single-cycle completion from memory; sampled only in REQ.
REQ-016 bus_rdata  input  32  load data, valid in the same cycle as bus_ack.

Function
REQ-017 The FSM SHALL have exactly three states: IDLE, REQ and DONE.
REQ-018 Access detect: acc = MemRead | MemWrite, and aligned = (ALUResult[1:0] == 0).
REQ-019 In IDLE, Stall SHALL equal acc & aligned, combinationally in the same cycle.
REQ-020 In REQ, Stall SHALL be 1.
REQ-021 In DONE, Stall SHALL be 0.
REQ-022 IDLE with acc & aligned SHALL, at the edge, move to REQ.
REQ-023 The same edge SHALL latch bus_addr = ALUResult, bus_wdata = WriteData and bus_we = MemWrite, and set bus_req = 1.
REQ-024 MemRead and MemWrite both high SHALL be treated as a store, with no error.
REQ-025 IDLE with acc & ~aligned SHALL issue no bus transaction, keep Stall = 0, pulse Err for one cycle (registered, next cycle) and remain in IDLE.
REQ-026 In REQ, bus_req, bus_we, bus_addr and bus_wdata SHALL hold stable regardless of datapath inputs.
REQ-027 REQ with bus_ack = 1 SHALL, at the edge, clear bus_req and move to DONE.
REQ-028 On that edge, a load SHALL capture ReadData = bus_rdata; a store SHALL leave ReadData unchanged.
REQ-029 The REQ wait counter (8 bits) SHALL clear on entry to REQ and increment each REQ cycle without ack.
REQ-030 On the edge where the count reaches TIMEOUT without ack, the block SHALL clear bus_req, load ReadData = 32'hDEADBEEF if the access is a load, pulse Err for one cycle and move to DONE.
REQ-031 When bus_ack arrives on the TIMEOUT cycle, ack SHALL win and no Err is raised.
REQ-032 DONE SHALL always return to IDLE on the next edge, ignoring acc, so the completing instruction never re-triggers.
REQ-033 An access in the cycle after DONE SHALL start normally per REQ-022.
REQ-034 Latency: if ack is sampled in the k-th REQ cycle, Stall SHALL be high for exactly k+1 cycles and ReadData SHALL be valid in DONE.
REQ-035 bus_ack in IDLE or DONE SHALL be ignored.

Reset
REQ-036 rst high SHALL immediately force state to IDLE, with no clock edge needed.
REQ-037 rst high SHALL immediately force bus_req = 0, bus_we = 0, bus_addr = 0, bus_wdata = 0, ReadData = 0, Err = 0, counter = 0 and Stall = 0.
REQ-038 Reset during REQ SHALL abandon the transaction; a bus_ack arriving after reset release SHALL be ignored.

Verification
REQ-039 Load, ack in first REQ cycle: MemRead = 1, ALUResult = 32'h100, bus_rdata = 32'hCAFEF00D -> Stall high for 2 cycles, bus_addr = 32'h100, bus_we = 0, ReadData = 32'hCAFEF00D in DONE.
REQ-040 Store, ack after 3 REQ cycles: MemWrite = 1, ALUResult = 32'h20, WriteData = 32'h12345678 -> bus_we = 1, bus_wdata = 32'h12345678 held for 3 cycles, Stall high for 4 cycles, ReadData unchanged.
REQ-041 Misaligned: MemRead = 1, ALUResult = 32'h102 -> bus_req never asserts, Stall = 0, Err pulses once.
REQ-042 Timeout: TIMEOUT = 4, MemRead = 1, no ack -> bus_req high for 4 cycles, then Err pulse, ReadData = 32'hDEADBEEF, return to IDLE; ack arriving exactly on cycle 4 -> no Err.
REQ-043 Back-to-back: two consecutive loads -> DONE→IDLE→REQ sequence, each load gets its own bus_req, no spurious re-trigger.
REQ-044 Reset asserted mid-REQ, async relative to clk -> bus_req and Stall drop immediately; a later bus_ack is ignored.
